// File: rtl/conv_pkg.sv
// Shared types and constant helpers for the convolution stage:
// the control-state enum, accumulator sizing, rounding bias and saturation limits.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    RND,
    OUT
  } state_e;

  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

  // Half-LSB of the post-shift result, giving round-half-up.
  function automatic longint round_bias(input int shift);
    if (shift > 0) return longint'(1) <<< (shift - 1);
    return 0;
  endfunction

endpackage

// File: rtl/conv_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation
// of a wide signed accumulator down to a DW-bit signed result.
module conv_round_sat
  import conv_pkg::*;
#(
  parameter int AW    = 26,
  parameter int DW    = 16,
  parameter int SHIFT = 2
) (
  input  logic signed [AW-1:0] acc,
  output logic signed [DW-1:0] res
);

  localparam logic signed [AW:0] BIAS = (AW + 1)'(round_bias(SHIFT));
  localparam logic signed [AW:0] MAXV = (AW + 1)'(sat_max(DW));
  localparam logic signed [AW:0] MINV = (AW + 1)'(sat_min(DW));

  logic signed [AW:0] biased;
  logic signed [AW:0] scaled;

  // One guard bit so the bias add cannot wrap at the top of the range.
  always_comb begin
    biased = (AW + 1)'(acc) + BIAS;
    scaled = biased >>> SHIFT;
    if (scaled > MAXV)      res = MAXV[DW-1:0];
    else if (scaled < MINV) res = MINV[DW-1:0];
    else                    res = scaled[DW-1:0];
  end

endmodule

// File: rtl/conv_mac.sv
// Streaming 1-D convolution: TAPS-deep sample window, one signed MAC per clock
// against programmable coefficients, rounded/saturated result on valid/ready.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CW    = 8,
  parameter int TAPS  = 3,
  parameter int SHIFT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [CW-1:0]           coef_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW-1:0]           data_out,
  output logic                    busy
);

  localparam int AW = acc_width(DW, CW, TAPS);
  localparam int KW = $clog2(TAPS);
  localparam int FW = $clog2(TAPS + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(TAPS);
  localparam logic [KW-1:0] K_LAST    = KW'(TAPS - 1);

  state_e                       state_q, state_d;
  logic [FW-1:0]                fill_q, fill_d;
  logic [KW-1:0]                k_q, k_d;
  logic signed [AW-1:0]         acc_q, acc_d;
  logic [TAPS-1:0][DW-1:0]      win_q, win_d;
  logic [TAPS-1:0][CW-1:0]      coef_q, coef_d;
  logic [DW-1:0]                data_out_q, data_out_d;
  logic [DW-1:0]                rs_out;
  logic signed [DW+CW-1:0]      prod;
  logic                         accept;

  assign accept   = in_valid && in_ready;
  assign prod     = $signed(win_q[k_q]) * $signed(coef_q[k_q]);
  assign data_out = data_out_q;

  conv_round_sat #(
    .AW   (AW),
    .DW   (DW),
    .SHIFT(SHIFT)
  ) u_round_sat (
    .acc(acc_q),
    .res(rs_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fill_q     <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      win_q      <= '0;
      coef_q     <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      win_q      <= win_d;
      coef_q     <= coef_d;
      data_out_q <= data_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && fill_d == FILL_FULL) state_d = MAC;
      MAC:     if (k_q == K_LAST) state_d = RND;
      RND:     state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in_ready is gated by rst_n so nothing looks acceptable while reset is held.
  always_comb begin
    in_ready  = rst_n && (state_q == IDLE);
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    fill_d     = fill_q;
    k_d        = k_q;
    acc_d      = acc_q;
    win_d      = win_q;
    coef_d     = coef_q;
    data_out_d = data_out_q;
    case (state_q)
      IDLE: begin
        if (coef_we && (32'(coef_addr) < 32'(TAPS))) coef_d[coef_addr] = coef_data;
        if (accept) begin
          win_d = {win_q[TAPS-2:0], data_in};
          if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
          k_d   = '0;
          acc_d = '0;
        end
      end
      MAC: begin
        acc_d = acc_q + AW'(prod);
        if (k_q != K_LAST) k_d = k_q + 1'b1;
      end
      RND:     data_out_d = rs_out;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_mac.sv
// Self-checking bench for conv_mac: directed scenarios plus randomized samples
// and coefficients, compared against an arithmetic convolution model.
module tb_conv_mac;

  localparam int DW    = 16;
  localparam int CW    = 8;
  localparam int TAPS  = 3;
  localparam int SHIFT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        coef_we;
  logic [1:0]  coef_addr;
  logic [7:0]  coef_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [15:0] last_out;

  int m_win[TAPS];
  int m_coef[TAPS];
  int m_fill;

  conv_mac #(
    .DW   (DW),
    .CW   (CW),
    .TAPS (TAPS),
    .SHIFT(SHIFT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Dot product of window and coefficients, then floor((sum + half) / 2^SHIFT), clamped.
  function automatic logic [15:0] model_out();
    longint s;
    longint q;
    longint div;
    s   = 0;
    div = longint'(1) << SHIFT;
    for (int i = 0; i < TAPS; i++) s += longint'(m_win[i]) * longint'(m_coef[i]);
    s += div / 2;
    q = s / div;
    if (s < 0 && (s % div) != 0) q -= 1;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return 16'(q);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      m_win[i]  = 0;
      m_coef[i] = 0;
    end
    m_fill = 0;
  endtask

  task automatic write_coef(input int a, input int v);
    coef_we   = 1'b1;
    coef_addr = 2'(a);
    coef_data = 8'(v);
    @(posedge clk); #1;
    coef_we   = 1'b0;
    m_coef[a] = v;
  endtask

  task automatic set_coefs(input int c0, input int c1, input int c2);
    write_coef(0, c0);
    write_coef(1, c1);
    write_coef(2, c2);
  endtask

  task automatic push_sample(input int x);
    int n;
    n        = 0;
    in_valid = 1'b1;
    data_in  = 16'(x);
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
    for (int i = TAPS - 1; i > 0; i--) m_win[i] = m_win[i-1];
    m_win[0] = x;
    if (m_fill < TAPS) m_fill++;
  endtask

  task automatic await_result(input int stall);
    logic [15:0] exp;
    logic [15:0] held;
    int n;
    n         = 0;
    exp       = model_out();
    out_ready = (stall == 0);
    while (out_valid !== 1'b1 && n < 12) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_in_ready: in_ready=%b required 0", in_ready);
      end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (cyc - acc_cyc != TAPS + 1) begin
      errors++;
      $display("FAIL latency: got %0d cycles required %0d", cyc - acc_cyc, TAPS + 1);
    end
    checks++;
    if (data_out !== exp) begin
      errors++;
      $display("FAIL result: data_out=%0d required %0d", $signed(data_out), $signed(exp));
    end
    held = data_out;
    repeat (stall) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || data_out !== held || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: out_valid=%b data_out=%0d in_ready=%b required 1/%0d/0",
                 out_valid, $signed(data_out), in_ready, $signed(held));
      end
    end
    last_out  = data_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic no_output(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL priming: out_valid=%b busy=%b required 0/0", out_valid, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || data_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b data_out=%h required 0/0/0/0000",
               in_ready, out_valid, busy, data_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_prime_smooth();
    int exp_list[3];
    int smp[3];
    exp_list = '{38, 23, 46};
    smp      = '{30, 21, 110};
    set_coefs(1, 2, 1);
    push_sample(100);
    no_output(6);
    push_sample(10);
    no_output(6);
    for (int i = 0; i < 3; i++) begin
      push_sample(smp[i]);
      await_result(0);
      checks++;
      if (last_out !== 16'(exp_list[i])) begin
        errors++;
        $display("FAIL smooth_value: got %0d required %0d", $signed(last_out), exp_list[i]);
      end
    end
  endtask

  task automatic test_saturation();
    set_coefs(127, 127, 127);
    repeat (3) begin
      push_sample(32767);
      await_result(0);
    end
    checks++;
    if (last_out !== 16'h7fff) begin
      errors++;
      $display("FAIL sat_pos: got %0d required 32767", $signed(last_out));
    end
    repeat (3) begin
      push_sample(-32768);
      await_result(0);
    end
    checks++;
    if (last_out !== 16'h8000) begin
      errors++;
      $display("FAIL sat_neg: got %0d required -32768", $signed(last_out));
    end
  endtask

  task automatic test_neg_round();
    set_coefs(1, 1, 1);
    repeat (3) begin
      push_sample(-50);
      await_result(0);
    end
    checks++;
    if (last_out !== 16'(-37)) begin
      errors++;
      $display("FAIL neg_round: got %0d required -37", $signed(last_out));
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    logic [15:0] held;
    int n;
    set_coefs(1, 2, 1);
    push_sample(1000);
    exp       = model_out();
    out_ready = 1'b0;
    n         = 0;
    while (out_valid !== 1'b1 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || data_out !== exp) begin
      errors++;
      $display("FAIL bp_result: out_valid=%b data_out=%0d required 1/%0d", out_valid, $signed(data_out), $signed(exp));
    end
    held     = data_out;
    in_valid = 1'b1;
    data_in  = 16'd77;
    repeat (20) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || data_out !== held || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: out_valid=%b data_out=%0d in_ready=%b busy=%b required 1/%0d/0/1",
                 out_valid, $signed(data_out), in_ready, busy, $signed(held));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept77: busy=%b required 1", busy);
    end
    for (int i = TAPS - 1; i > 0; i--) m_win[i] = m_win[i-1];
    m_win[0] = 77;
    await_result(0);
  endtask

  task automatic test_coef_busy();
    push_sample(7);
    coef_we   = 1'b1;
    coef_addr = 2'd1;
    coef_data = 8'd5;
    @(posedge clk); #1;
    coef_we = 1'b0;
    await_result(0);
    write_coef(1, 5);
    push_sample(9);
    await_result(0);
    // Write and accept on the same cycle: new coefficient applies to this sample.
    coef_we   = 1'b1;
    coef_addr = 2'd0;
    coef_data = 8'd3;
    m_coef[0] = 3;
    push_sample(-20);
    coef_we = 1'b0;
    await_result(0);
    set_coefs(1, 2, 1);
  endtask

  task automatic test_reset_mid();
    push_sample(11);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || data_out !== 16'h0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b data_out=%h in_ready=%b busy=%b required 0/0000/0/0",
               out_valid, data_out, in_ready, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    set_coefs(1, 2, 1);
    push_sample(40);
    no_output(8);
    push_sample(50);
    no_output(8);
    push_sample(60);
    await_result(0);
    checks++;
    if (last_out !== 16'd50) begin
      errors++;
      $display("FAIL reset_mid_refill: got %0d required 50", $signed(last_out));
    end
  endtask

  task automatic test_random();
    int x;
    repeat (40) begin
      if ($urandom_range(0, 3) == 0)
        write_coef(int'($urandom_range(0, TAPS - 1)), int'($signed(8'($urandom))));
      x = int'($signed(16'($urandom)));
      push_sample(x);
      if (m_fill == TAPS) await_result(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_prime_smooth();
    test_saturation();
    test_neg_round();
    test_backpressure();
    test_coef_busy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
